// File: rtl/answer_pkg.sv
// Shared encodings for the answer checker.
//   state_e  : round state reported on state_o (IDLE/PLAY/WIN/LOSE)
//   result_e : per-guess verdict (NONE/HIGH/LOW/CORRECT)
//   ANS_W_DEF: default width of the answer and guess fields
package answer_pkg;

    localparam int ANS_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_HIGH    = 2'd1,
        RES_LOW     = 2'd2,
        RES_CORRECT = 2'd3
    } result_e;

endpackage

// File: rtl/answer_checker_if.sv
// Handshake/bus bundle between the game logic and the answer checker.
//   rand_in, write_enable   : new-answer load from the random generator
//   guess, guess_valid      : player guess strobe
//   answer, result, result_valid, attempts, state_o : checker outputs
// master = the side producing answers/guesses, slave = the checker.
interface answer_checker_if #(
    parameter int ANS_W = 4,
    parameter int CNT_W = 4
);
    logic [31:0]      rand_in;
    logic             write_enable;
    logic [ANS_W-1:0] guess;
    logic             guess_valid;
    logic [ANS_W-1:0] answer;
    logic [1:0]       result;
    logic             result_valid;
    logic [CNT_W-1:0] attempts;
    logic [1:0]       state_o;

    modport master (
        output rand_in, write_enable, guess, guess_valid,
        input  answer, result, result_valid, attempts, state_o
    );

    modport slave (
        input  rand_in, write_enable, guess, guess_valid,
        output answer, result, result_valid, attempts, state_o
    );
endinterface

// File: rtl/answer_checker_guess_compare.sv
// Combinational unsigned compare of a guess against the secret answer.
//   guess, answer : ANS_W-bit unsigned operands
//   verdict       : HIGH (guess > answer), LOW (guess < answer), CORRECT
module guess_compare
    import answer_pkg::*;
#(
    parameter int ANS_W = ANS_W_DEF
) (
    input  logic [ANS_W-1:0] guess,
    input  logic [ANS_W-1:0] answer,
    output result_e          verdict
);

    always_comb begin
        verdict = RES_CORRECT;
        if (guess > answer)
            verdict = RES_HIGH;
        else if (guess < answer)
            verdict = RES_LOW;
    end

endmodule

// File: rtl/answer_checker.sv
// Answer checker: latches a secret answer from the random generator, scores
// player guesses one cycle after their strobe and tracks the round state.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : answer_checker_if slave (inputs rand_in/write_enable/guess/
//              guess_valid, registered outputs answer/result/result_valid/
//              attempts/state_o)
// Optional feature: define ATTEMPT_LIMIT_EN to end the round in LOSE after
// MAX_TRIES wrong guesses; otherwise guessing is unlimited.
//
// state | meaning
// IDLE  | no answer loaded yet, guesses ignored
// PLAY  | answer loaded, guesses scored
// WIN   | correct guess seen, waiting for a new answer
// LOSE  | guess budget used up, waiting for a new answer
module answer_checker
    import answer_pkg::*;
#(
    parameter int ANS_W     = ANS_W_DEF,
    parameter int MAX_TRIES = 3,
    parameter int CNT_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    answer_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state;
    result_e          result;
    result_e          verdict;
    logic [ANS_W-1:0] answer;
    logic [CNT_W-1:0] attempts;
    logic [CNT_W-1:0] attempts_nxt;
    logic             result_valid;
    logic             limit_hit;

    guess_compare #(.ANS_W(ANS_W)) u_compare (
        .guess   (bus.guess),
        .answer  (answer),
        .verdict (verdict)
    );

    assign attempts_nxt = (attempts == CNT_MAX) ? attempts : attempts + 1'b1;
    assign limit_hit    = (attempts_nxt == CNT_W'(MAX_TRIES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            result       <= RES_NONE;
            result_valid <= 1'b0;
            answer       <= '0;
            attempts     <= '0;
        end else begin
            result_valid <= 1'b0;
            // A load always wins over a coincident guess, in every state.
            if (bus.write_enable) begin
                state    <= ST_PLAY;
                answer   <= bus.rand_in[ANS_W-1:0];
                attempts <= '0;
                result   <= RES_NONE;
            end else if (bus.guess_valid && state == ST_PLAY) begin
                result_valid <= 1'b1;
                result       <= verdict;
                attempts     <= attempts_nxt;
                if (verdict == RES_CORRECT)
                    state <= ST_WIN;
`ifdef ATTEMPT_LIMIT_EN
                else if (limit_hit)
                    state <= ST_LOSE;
`endif
            end
        end
    end

`ifdef ATTEMPT_LIMIT_EN
    logic unused_bits;
    assign unused_bits = ^bus.rand_in[31:ANS_W];
`else
    logic unused_bits;
    assign unused_bits = ^{bus.rand_in[31:ANS_W], limit_hit};
`endif

    assign bus.answer       = answer;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.attempts     = attempts;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_answer_checker.sv
module tb_answer_checker;

    localparam int ANS_W     = 4;
    localparam int CNT_W     = 4;
    localparam int MAX_TRIES = 3;
    localparam int SAT       = (1 << CNT_W) - 1;
`ifdef ATTEMPT_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    answer_checker_if #(.ANS_W(ANS_W), .CNT_W(CNT_W)) bus ();

    answer_checker #(.ANS_W(ANS_W), .MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: game rules in plain integers.
    // state 0=IDLE 1=PLAY 2=WIN 3=LOSE; result 0=NONE 1=HIGH 2=LOW 3=CORRECT
    int m_state = 0, m_answer = 0, m_att = 0, m_res = 0, m_rv = 0;
    bit armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_answer = 0; m_att = 0; m_res = 0; m_rv = 0;
            armed = 1'b1;
        end else begin
            m_rv = 0;
            if (bus.write_enable) begin
                m_state  = 1;
                m_answer = int'(bus.rand_in % 32'(1 << ANS_W));
                m_att    = 0;
                m_res    = 0;
            end else if (bus.guess_valid && m_state == 1) begin
                int g;
                g = int'(bus.guess);
                m_rv = 1;
                if (g == m_answer)     m_res = 3;
                else if (g > m_answer) m_res = 1;
                else                   m_res = 2;
                m_att = (m_att < SAT) ? m_att + 1 : SAT;
                if (m_res == 3)
                    m_state = 2;
                else if (LIMIT && m_att == MAX_TRIES)
                    m_state = 3;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model.state_o",      int'(bus.state_o),      m_state);
            chk("model.answer",       int'(bus.answer),       m_answer);
            chk("model.attempts",     int'(bus.attempts),     m_att);
            chk("model.result",       int'(bus.result),       m_res);
            chk("model.result_valid", int'(bus.result_valid), m_rv);
        end
    end

    // Drive one cycle of inputs; on return the outputs reflect this cycle.
    task automatic step(input bit we, input int rnd, input bit gv, input int g);
        bus.write_enable = we;
        bus.rand_in      = 32'(rnd);
        bus.guess_valid  = gv;
        bus.guess        = ANS_W'(g);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        bus.write_enable = 1'b0;
        bus.rand_in      = '0;
        bus.guess_valid  = 1'b0;
        bus.guess        = '0;
        @(negedge clk);
        do_reset();

        // reset values; guess in IDLE ignored
        chk("rst.state",    int'(bus.state_o),  0);
        chk("rst.answer",   int'(bus.answer),   0);
        chk("rst.result",   int'(bus.result),   0);
        step(0, 0, 1, 5);
        chk("idle.rv",       int'(bus.result_valid), 0);
        chk("idle.state",    int'(bus.state_o),      0);
        chk("idle.attempts", int'(bus.attempts),     0);

        // answer 6, guesses 3, 8, 6 back to back
        step(1, 6, 0, 0);
        chk("load.state",  int'(bus.state_o), 1);
        chk("load.answer", int'(bus.answer),  6);
        step(0, 0, 1, 3);
        chk("g3.result", int'(bus.result), 2);
        chk("g3.rv",     int'(bus.result_valid), 1);
        chk("g3.att",    int'(bus.attempts), 1);
        step(0, 0, 1, 8);
        chk("g8.result", int'(bus.result), 1);
        chk("g8.rv",     int'(bus.result_valid), 1);
        chk("g8.att",    int'(bus.attempts), 2);
        step(0, 0, 1, 6);
        chk("g6.result", int'(bus.result), 3);
        chk("g6.att",    int'(bus.attempts), 3);
        chk("g6.state",  int'(bus.state_o), 2);
        step(0, 0, 1, 5);
        chk("win.rv",    int'(bus.result_valid), 0);
        chk("win.att",   int'(bus.attempts), 3);
        step(0, 0, 0, 0);

`ifdef ATTEMPT_LIMIT_EN
        step(1, 2, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 4);
        chk("lim.state2", int'(bus.state_o), 1);
        step(0, 0, 1, 7);
        chk("lim.result", int'(bus.result), 1);
        chk("lim.rv",     int'(bus.result_valid), 1);
        chk("lim.state",  int'(bus.state_o), 3);
        step(1, 4, 0, 0);
        chk("relim.state",  int'(bus.state_o), 1);
        chk("relim.answer", int'(bus.answer), 4);
        chk("relim.att",    int'(bus.attempts), 0);
`endif

        // write_enable beats a coincident guess
        step(1, 5, 0, 0);
        step(0, 0, 1, 3);
        chk("pre.result", int'(bus.result), 2);
        step(1, 1, 1, 5);
        chk("both.rv",     int'(bus.result_valid), 0);
        chk("both.answer", int'(bus.answer), 1);
        chk("both.att",    int'(bus.attempts), 0);
        chk("both.result", int'(bus.result), 0);

        // reset mid-round
        step(1, 7, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 2);
        do_reset();
        chk("mid.answer", int'(bus.answer),   0);
        chk("mid.att",    int'(bus.attempts), 0);
        chk("mid.state",  int'(bus.state_o),  0);
        chk("mid.result", int'(bus.result),   0);

`ifndef ATTEMPT_LIMIT_EN
        // saturation without a guess limit
        step(1, 4, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
        chk("sat.att",   int'(bus.attempts), 15);
        chk("sat.state", int'(bus.state_o), 1);
        step(0, 0, 1, 4);
        chk("sat.win",   int'(bus.state_o), 2);
        chk("sat.res",   int'(bus.result), 3);
        chk("sat.att2",  int'(bus.attempts), 15);
`endif

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] r;
            r = $urandom;
            r[3:0] = 4'($urandom_range(1, 8));
            if ($urandom_range(0, 31) == 0) r[3:0] = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 99) == 0);
            step(($urandom_range(0, 9) == 0), int'(r),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 10)));
        end
        rst = 1'b0;
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
